reg_file_nz_scan: RTL and testbench



---
 rtl/reg_file_pkg.sv | 28 ++
 rtl/nz_priority_enc.sv | 31 +++
 rtl/reg_file_nz_scan.sv | 158 +++++++++++++++
 tb/tb_reg_file_nz_scan.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the nonzero-scanning register file.
package reg_file_pkg;

    // Ceiling log2, minimum 1 so a 2-entry file still gets a 1-bit address.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if (((n - 1) >> i) != 0) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

    typedef enum logic {
        SCAN_IDLE   = 1'b0,
        SCAN_ACTIVE = 1'b1
    } scan_state_t;

    // A same-cycle write is forwarded only when it will actually land in the array.
    function automatic logic fwd_sel(input logic wr_en,
                                     input logic clear,
                                     input logic addr_match);
        return wr_en && !clear && addr_match;
    endfunction

endpackage

// File: rtl/nz_priority_enc.sv
// Find-first-set over a masked vector, with a flag for any set bit above the winner.
module nz_priority_enc
    import reg_file_pkg::*;
#(
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned IW    = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IW-1:0]    idx_o,
    output logic             found_o,
    output logic             more_o
);

    logic [WIDTH-1:0] lowest_onehot;

    // Descending walk so the last hit written is the lowest set bit.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IW'(i);
                found_o = 1'b1;
            end
        end
    end

    assign lowest_onehot = vec_i & (~vec_i + WIDTH'(1));
    assign more_o        = |(vec_i & ~lowest_onehot);

endmodule

// File: rtl/reg_file_nz_scan.sv
// Multi-read-port register file with forwarding, nonzero flags and a nonzero-entry scanner.
// Scanner is built only when REG_FILE_NZ_SCAN_EN is defined; otherwise its outputs are tied 0.
module reg_file_nz_scan
    import reg_file_pkg::*;
#(
    parameter  int unsigned BIT_WIDTH    = 16,
    parameter  int unsigned REG_DEPTH    = 64,
    parameter  int unsigned NUM_RD_PORTS = 2,
    localparam int unsigned AW           = clog2(REG_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clear,
    input  logic [NUM_RD_PORTS-1:0]           rd_en,
    input  logic [NUM_RD_PORTS*AW-1:0]        rd_addr,
    output logic [NUM_RD_PORTS*BIT_WIDTH-1:0] rd_data,
    input  logic                              wr_en,
    input  logic [AW-1:0]                     wr_addr,
    input  logic [BIT_WIDTH-1:0]              wr_data,
    output logic [REG_DEPTH-1:0]              nz_flags,
    input  logic                              scan_start,
    output logic                              scan_busy,
    output logic                              scan_valid,
    input  logic                              scan_ready,
    output logic [AW-1:0]                     scan_idx,
    output logic [BIT_WIDTH-1:0]              scan_data,
    output logic                              scan_last,
    output logic                              scan_done
);

    logic [BIT_WIDTH-1:0] mem_q [REG_DEPTH];
    logic [BIT_WIDTH-1:0] mem_d [REG_DEPTH];

    // Clear outranks the write port.
    always_comb begin
        mem_d = mem_q;
        if (clear) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < REG_DEPTH; i++) begin : g_nz
        assign nz_flags[i] = |mem_q[i];
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] port_addr;
        assign port_addr = rd_addr[p*AW +: AW];
        assign rd_data[p*BIT_WIDTH +: BIT_WIDTH] =
            !rd_en[p]                                  ? '0      :
            fwd_sel(wr_en, clear, port_addr == wr_addr) ? wr_data :
                                                         mem_q[port_addr];
    end

`ifdef REG_FILE_NZ_SCAN_EN

    scan_state_t      state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             done_q, done_d;
    logic [REG_DEPTH-1:0] cand;
    logic [AW-1:0]    enc_idx;
    logic             enc_found;
    logic             enc_more;
    logic             active;
    logic             pair_valid;

    // Flags are live, so entries written mid-scan at or above ptr are picked up.
    assign cand = nz_flags & ({REG_DEPTH{1'b1}} << ptr_q);

    nz_priority_enc #(
        .WIDTH (REG_DEPTH)
    ) u_enc (
        .vec_i   (cand),
        .idx_o   (enc_idx),
        .found_o (enc_found),
        .more_o  (enc_more)
    );

    assign active     = (state_q == SCAN_ACTIVE);
    assign pair_valid = active && enc_found;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            SCAN_IDLE: begin
                if (scan_start && !clear) begin
                    state_d = SCAN_ACTIVE;
                    ptr_d   = '0;
                end
            end
            SCAN_ACTIVE: begin
                if (clear) begin
                    state_d = SCAN_IDLE;
                end else if (!enc_found) begin
                    state_d = SCAN_IDLE;
                    done_d  = 1'b1;
                end else if (scan_ready) begin
                    ptr_d = enc_idx + AW'(1);
                    if (!enc_more) begin
                        state_d = SCAN_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = SCAN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SCAN_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign scan_busy  = active;
    assign scan_valid = pair_valid;
    assign scan_idx   = pair_valid ? enc_idx : '0;
    assign scan_last  = pair_valid && !enc_more;
    assign scan_done  = done_q;
    assign scan_data  = !pair_valid                                ? '0      :
                        fwd_sel(wr_en, clear, enc_idx == wr_addr)  ? wr_data :
                                                                     mem_q[enc_idx];

`else

    logic unused_scan_inputs;
    assign unused_scan_inputs = ^{scan_start, scan_ready};

    assign scan_busy  = 1'b0;
    assign scan_valid = 1'b0;
    assign scan_idx   = '0;
    assign scan_data  = '0;
    assign scan_last  = 1'b0;
    assign scan_done  = 1'b0;

`endif

endmodule

// File: tb/tb_reg_file_nz_scan.sv
// Directed bench for reg_file_nz_scan: table-driven read/write/forwarding vectors plus scanner sequences.
module tb_reg_file_nz_scan;

    localparam int unsigned BW = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic [NP-1:0]     rd_en;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*BW-1:0]  rd_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [BW-1:0]     wr_data;
    logic [DEPTH-1:0]  nz_flags;
    logic              scan_start;
    logic              scan_busy;
    logic              scan_valid;
    logic              scan_ready;
    logic [AW-1:0]     scan_idx;
    logic [BW-1:0]     scan_data;
    logic              scan_last;
    logic              scan_done;

    int total = 0;
    int bad   = 0;
    int k;

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [BW-1:0] wr_data;
        logic [1:0]    en;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [BW-1:0] e0;
        logic [BW-1:0] e1;
        logic [63:0]   enz;
    } vec_t;

    vec_t tbl [8];

    logic [AW-1:0] exp_idx [3];
    logic [BW-1:0] exp_dat [3];

    always #5 clk = ~clk;

    reg_file_nz_scan #(
        .BIT_WIDTH    (BW),
        .REG_DEPTH    (DEPTH),
        .NUM_RD_PORTS (NP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .nz_flags   (nz_flags),
        .scan_start (scan_start),
        .scan_busy  (scan_busy),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .scan_idx   (scan_idx),
        .scan_data  (scan_data),
        .scan_last  (scan_last),
        .scan_done  (scan_done)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [BW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; rd_en = '0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        scan_start = 1'b0; scan_ready = 1'b0;

        tbl[0] = '{1'b0, 6'd0,  16'h0000, 2'b11, 6'd0,  6'd63, 16'h0000, 16'h0000, 64'h0};
        tbl[1] = '{1'b1, 6'd5,  16'h1234, 2'b11, 6'd5,  6'd5,  16'h1234, 16'h1234, 64'h0};
        tbl[2] = '{1'b0, 6'd0,  16'h0000, 2'b11, 6'd5,  6'd4,  16'h1234, 16'h0000, 64'h20};
        tbl[3] = '{1'b1, 6'd3,  16'h00AA, 2'b01, 6'd3,  6'd5,  16'h00AA, 16'h0000, 64'h20};
        tbl[4] = '{1'b1, 6'd10, 16'h0BEE, 2'b11, 6'd3,  6'd5,  16'h00AA, 16'h1234, 64'h28};
        tbl[5] = '{1'b1, 6'd63, 16'hFFFF, 2'b11, 6'd10, 6'd63, 16'h0BEE, 16'hFFFF, 64'h428};
        tbl[6] = '{1'b1, 6'd5,  16'h0000, 2'b11, 6'd5,  6'd63, 16'h0000, 16'hFFFF, 64'h8000_0000_0000_0428};
        tbl[7] = '{1'b0, 6'd0,  16'h0000, 2'b11, 6'd5,  6'd5,  16'h0000, 16'h0000, 64'h8000_0000_0000_0408};

        exp_idx[0] = 6'd3;  exp_dat[0] = 16'h00AA;
        exp_idx[1] = 6'd10; exp_dat[1] = 16'h0BEE;
        exp_idx[2] = 6'd63; exp_dat[2] = 16'hFFFF;

        step(); step();
        rst_n = 1'b1;
        step();

        chk("rst_nz", 64'(nz_flags), 64'h0);
        chk("rst_busy", 64'(scan_busy), 64'h0);
        chk("rst_valid", 64'(scan_valid), 64'h0);
        chk("rst_done", 64'(scan_done), 64'h0);
        rd_en = 2'b11;
        for (int a = 0; a < 64; a++) begin
            rd_addr = {6'(63 - a), 6'(a)};
            #1;
            chk("rst_rd", 64'(rd_data), 64'h0);
        end

        for (int i = 0; i < 8; i++) begin
            wr_en = tbl[i].wr_en; wr_addr = tbl[i].wr_addr; wr_data = tbl[i].wr_data;
            rd_en = tbl[i].en; rd_addr = {tbl[i].a1, tbl[i].a0};
            #1;
            chk($sformatf("vec%0d_rd0", i), 64'(rd_data[15:0]), 64'(tbl[i].e0));
            chk($sformatf("vec%0d_rd1", i), 64'(rd_data[31:16]), 64'(tbl[i].e1));
            chk($sformatf("vec%0d_nz", i), 64'(nz_flags), tbl[i].enz);
            step();
        end
        wr_en = 1'b0;

`ifdef REG_FILE_NZ_SCAN_EN
        // Continuous-ready scan over entries 3, 10, 63.
        scan_ready = 1'b1; scan_start = 1'b1;
        #1;
        chk("a_pre_busy", 64'(scan_busy), 64'h0);
        step();
        scan_start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk($sformatf("a_valid%0d", j), 64'(scan_valid), 64'h1);
            chk($sformatf("a_idx%0d", j), 64'(scan_idx), 64'(exp_idx[j]));
            chk($sformatf("a_data%0d", j), 64'(scan_data), 64'(exp_dat[j]));
            chk($sformatf("a_last%0d", j), 64'(scan_last), (j == 2) ? 64'h1 : 64'h0);
            chk($sformatf("a_done%0d", j), 64'(scan_done), 64'h0);
            step();
        end
        chk("a_done", 64'(scan_done), 64'h1);
        chk("a_busy_after", 64'(scan_busy), 64'h0);
        chk("a_valid_after", 64'(scan_valid), 64'h0);
        step();
        chk("a_done_pulse", 64'(scan_done), 64'h0);

        // Toggling ready: each pair held while ready=0.
        scan_start = 1'b1; scan_ready = 1'b0;
        step();
        scan_start = 1'b0;
        k = 0;
        for (int c = 0; c < 12 && k < 3; c++) begin
            scan_ready = (c % 2 == 1);
            #1;
            chk($sformatf("b_valid_c%0d", c), 64'(scan_valid), 64'h1);
            chk($sformatf("b_idx_c%0d", c), 64'(scan_idx), 64'(exp_idx[k]));
            chk($sformatf("b_data_c%0d", c), 64'(scan_data), 64'(exp_dat[k]));
            chk($sformatf("b_last_c%0d", c), 64'(scan_last), (k == 2) ? 64'h1 : 64'h0);
            step();
            if (scan_ready) k++;
        end
        chk("b_count", 64'(k), 64'd3);
        chk("b_done", 64'(scan_done), 64'h1);
        scan_ready = 1'b1;
`endif

        // Empty the file; busy for one cycle with no data, done the cycle after.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("c_nz_clear", 64'(nz_flags), 64'h0);
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
`ifdef REG_FILE_NZ_SCAN_EN
        chk("c_busy_t1", 64'(scan_busy), 64'h1);
        chk("c_valid_t1", 64'(scan_valid), 64'h0);
        chk("c_done_t1", 64'(scan_done), 64'h0);
        step();
        chk("c_done_t2", 64'(scan_done), 64'h1);
        chk("c_valid_t2", 64'(scan_valid), 64'h0);
        chk("c_busy_t2", 64'(scan_busy), 64'h0);
        step();
        chk("c_done_t3", 64'(scan_done), 64'h0);
`else
        chk("c_off_busy", 64'(scan_busy), 64'h0);
        step();
        chk("c_off_done", 64'(scan_done), 64'h0);
`endif

        // Mid-scan clear racing a write to entry 7.
        write(6'd7, 16'h0077);
        write(6'd20, 16'h2020);
        chk("d_nz_pre", 64'(nz_flags), 64'h0010_0080);
        scan_ready = 1'b0; scan_start = 1'b1;
        step();
        scan_start = 1'b0;
`ifdef REG_FILE_NZ_SCAN_EN
        chk("d_valid", 64'(scan_valid), 64'h1);
        chk("d_idx", 64'(scan_idx), 64'd7);
`else
        chk("d_off_valid", 64'(scan_valid), 64'h0);
        chk("d_off_idx", 64'(scan_idx), 64'h0);
        chk("d_off_data", 64'(scan_data), 64'h0);
`endif
        clear = 1'b1; wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'hBEEF;
        rd_en = 2'b01; rd_addr = {6'd0, 6'd7};
        #1;
        chk("d_rd_old", 64'(rd_data[15:0]), 64'h0077);
`ifdef REG_FILE_NZ_SCAN_EN
        chk("d_scan_data_old", 64'(scan_data), 64'h0077);
`endif
        step();
        clear = 1'b0; wr_en = 1'b0;
        #1;
        chk("d_rd7_after", 64'(rd_data[15:0]), 64'h0);
        chk("d_nz_after", 64'(nz_flags), 64'h0);
        chk("d_busy_after", 64'(scan_busy), 64'h0);
        chk("d_valid_after", 64'(scan_valid), 64'h0);
        chk("d_done_after", 64'(scan_done), 64'h0);
        step();
        chk("d_done_later", 64'(scan_done), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
